// File: rtl/mpu_pkg.sv
// Shared types and constants for the MPU transpose sequencer.
// Matrix elements are opaque bytes; no arithmetic is done on them.
package mpu_pkg;

  localparam int DATA_W = 8;
  localparam int MAT_N  = 5;
  localparam int N_ELEM = MAT_N * MAT_N;
  localparam int IDX_W  = $clog2(N_ELEM);
  localparam int RC_W   = $clog2(MAT_N);

  typedef logic [DATA_W-1:0] elem_t;
  typedef elem_t [MAT_N-1:0][MAT_N-1:0] mat_t;

  typedef enum logic {
    OP_PASS,
    OP_TRANSPOSE
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DRAIN
  } state_e;

endpackage

// File: rtl/mpu_transpose_seq_if.sv
// Host/DMA side bundle: command, input stream, output stream, status.
// master drives stimulus, slave is the sequencer.
interface mpu_transpose_seq_if;
  import mpu_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  logic  cmd_op;
  logic  in_valid;
  logic  in_ready;
  elem_t in_data;
  logic  out_valid;
  logic  out_ready;
  elem_t out_data;
  logic  out_last;
  logic  busy;
  logic  done;

  modport master (
    output cmd_valid, cmd_op,
    output in_valid, in_data,
    output out_ready,
    input  cmd_ready, in_ready,
    input  out_valid, out_data,
    input  out_last, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op,
    input  in_valid, in_data,
    input  out_ready,
    output cmd_ready, in_ready,
    output out_valid, out_data,
    output out_last, busy, done
  );

endinterface

// File: rtl/mpu_transpose_core.sv
// Combinational 5x5 transpose datapath: mat_o[i][j] = mat_i[j][i].
// Pure wiring, no logic depth.
module mpu_transpose_core
  import mpu_pkg::*;
(
  input  mat_t mat_i,
  output mat_t mat_o
);

  for (genvar i = 0; i < MAT_N; i++) begin : g_row
    for (genvar j = 0; j < MAT_N; j++) begin : g_col
      assign mat_o[i][j] = mat_i[j][i];
    end
  end

endmodule

// File: rtl/mpu_transpose_seq.sv
// Sequencer: load 25 bytes row-major, run transpose/pass once,
// then drain 25 bytes row-major with backpressure.
module mpu_transpose_seq
  import mpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mpu_transpose_seq_if.slave  bus
);

  state_e          state_q, state_d;
  logic [RC_W-1:0] row_q, row_d;
  logic [RC_W-1:0] col_q, col_d;
  op_e             op_q, op_d;
  logic            done_q, done_d;
  mat_t            buf_q;
  mat_t            res_q;
  mat_t            tr_w;
  logic            at_end;
  logic            in_fire;

  localparam logic [RC_W-1:0] LastRc = RC_W'(MAT_N - 1);

  assign at_end  = (row_q == LastRc) && (col_q == LastRc);
  assign in_fire = (state_q == S_LOAD) && bus.in_valid;

  mpu_transpose_core u_core (
    .mat_i (buf_q),
    .mat_o (tr_w)
  );

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    op_d    = op_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d    = op_e'(bus.cmd_op);
          row_d   = '0;
          col_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          if (col_q == LastRc) begin
            col_d = '0;
            row_d = at_end ? '0 : row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
          if (at_end) state_d = S_EXEC;
        end
      end
      S_EXEC: state_d = S_DRAIN;
      S_DRAIN: begin
        if (bus.out_ready) begin
          if (col_q == LastRc) begin
            col_d = '0;
            row_d = at_end ? '0 : row_q + RC_W'(1);
          end else begin
            col_d = col_q + RC_W'(1);
          end
          if (at_end) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      op_q    <= OP_PASS;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  // Matrix storage needs no reset; it is always fully rewritten
  always_ff @(posedge clk) begin
    if (in_fire) buf_q[row_q][col_q] <= bus.in_data;
    if (state_q == S_EXEC) begin
      res_q <= (op_q == OP_TRANSPOSE) ? tr_w : buf_q;
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.in_ready  = (state_q == S_LOAD);
  assign bus.out_valid = (state_q == S_DRAIN);
  assign bus.out_data  = (state_q == S_DRAIN) ? res_q[row_q][col_q] : '0;
  assign bus.out_last  = (state_q == S_DRAIN) && at_end;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_mpu_transpose_seq.sv
// Randomized bench for mpu_transpose_seq against a matrix model.
// Drives at #1 after posedge, samples before the next edge.
module tb_mpu_transpose_seq;

  typedef logic [7:0] arr_t [25];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mpu_transpose_seq_if bus();

  mpu_transpose_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] r_got[$];
  logic [7:0] r_held[$];
  int r_lastcnt, r_lastpos, r_done_cyc, r_wait;
  int r_busy_cmd, r_spur_bad;
  bit r_to, r_done_cmdrdy, r_aborted;
  logic r_ab_ov, r_ab_busy;

  function automatic arr_t ref_model(input bit op, input arr_t d);
    arr_t e;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        e[r*5+c] = op ? d[c*5+r] : d[r*5+c];
    return e;
  endfunction

  task automatic run_txn(input bit op, input arr_t d,
                         input int gap, input int stall_at,
                         input int stall_len, input bit keep_cmd,
                         input bit spur, input int abort_at);
    int n, in_idx, stall_cnt;
    r_got.delete(); r_held.delete();
    r_lastcnt = 0; r_lastpos = -1; r_done_cyc = -1;
    r_wait = 0; r_busy_cmd = 0; r_spur_bad = 0;
    r_to = 0; r_done_cmdrdy = 0; r_aborted = 0;
    r_ab_ov = 1'b1; r_ab_busy = 1'b1;
    bus.cmd_op = op;
    bus.cmd_valid = 1'b1;
    while (!bus.cmd_ready && r_wait < 200) begin
      @(posedge clk); #1; r_wait++;
    end
    if (!bus.cmd_ready) begin
      r_to = 1; bus.cmd_valid = 1'b0; return;
    end
    in_idx = 0; stall_cnt = 0;
    @(posedge clk); #1; n = 1;
    if (!keep_cmd) bus.cmd_valid = 1'b0;
    while (n < 400) begin
      bus.in_valid = (in_idx < 25 && $urandom_range(99) >= gap)
                  || (spur && in_idx >= 25 && $urandom_range(1) == 1);
      bus.in_data = (in_idx < 25) ? d[in_idx] : 8'($urandom);
      if (bus.out_valid && r_got.size() == stall_at
          && stall_cnt < stall_len) begin
        bus.out_ready = 1'b0;
        r_held.push_back(bus.out_data);
        stall_cnt++;
      end else if (bus.out_valid) begin
        bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = spur ? 1'($urandom_range(1)) : 1'b0;
      end
      if (abort_at >= 0 && bus.out_valid && r_got.size() == abort_at) begin
        rst_n = 1'b0; #1;
        r_ab_ov = bus.out_valid; r_ab_busy = bus.busy; r_aborted = 1;
        bus.in_valid = 0; bus.out_ready = 0; bus.cmd_valid = 0;
        return;
      end
      if (bus.busy && bus.cmd_ready) r_busy_cmd++;
      if (bus.in_ready && in_idx >= 25) r_spur_bad++;
      if (bus.done) begin
        r_done_cyc = n; r_done_cmdrdy = bus.cmd_ready; break;
      end
      if (bus.in_ready && bus.in_valid && in_idx < 25) in_idx++;
      if (bus.out_valid && bus.out_ready) begin
        r_got.push_back(bus.out_data);
        if (bus.out_last) begin
          r_lastcnt++; r_lastpos = r_got.size() - 1;
        end
      end
      @(posedge clk); #1; n++;
    end
    if (r_done_cyc < 0) r_to = 1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cmd_valid = 0; bus.cmd_op = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 0;
    #3;
    checks++;
    if (bus.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL rst_cmd_ready got %b want 1", bus.cmd_ready);
    end
    checks++;
    if ({bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done} !== 5'b0) begin
      errors++;
      $display("FAIL rst_flags got %b want 00000",
               {bus.in_ready, bus.out_valid, bus.out_last, bus.busy, bus.done});
    end
    checks++;
    if (bus.out_data !== 8'h00) begin
      errors++; $display("FAIL rst_out_data got %h want 00", bus.out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_transpose();
    arr_t d, e;
    for (int i = 0; i < 25; i++) d[i] = 8'(i);
    e = ref_model(1'b1, d);
    run_txn(1'b1, d, 0, -1, 0, 1'b0, 1'b0, -1);
    checks++;
    if (r_to) begin errors++; $display("FAIL tr_timeout got 1 want 0"); end
    for (int i = 0; i < 25; i++) begin
      logic [7:0] g;
      g = (i < r_got.size()) ? r_got[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errors++; $display("FAIL tr_elem[%0d] got %h want %h", i, g, e[i]);
      end
    end
    checks++;
    if (r_lastcnt != 1 || r_lastpos != 24) begin
      errors++;
      $display("FAIL tr_last got cnt=%0d pos=%0d want cnt=1 pos=24",
               r_lastcnt, r_lastpos);
    end
    checks++;
    if (r_done_cyc != 52) begin
      errors++; $display("FAIL tr_done_cycle got %0d want 52", r_done_cyc);
    end
    checks++;
    if (r_got.size() != 25) begin
      errors++; $display("FAIL tr_count got %0d want 25", r_got.size());
    end
  endtask

  task automatic test_pass();
    arr_t d, e;
    for (int i = 0; i < 25; i++) d[i] = 8'(8'h80 + i);
    e = ref_model(1'b0, d);
    run_txn(1'b0, d, 0, -1, 0, 1'b0, 1'b0, -1);
    checks++;
    if (r_to || r_got.size() != 25) begin
      errors++; $display("FAIL pass_count got %0d want 25", r_got.size());
    end
    for (int i = 0; i < 25; i++) begin
      logic [7:0] g;
      g = (i < r_got.size()) ? r_got[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errors++; $display("FAIL pass_elem[%0d] got %h want %h", i, g, e[i]);
      end
    end
    checks++;
    if (r_done_cyc != 52) begin
      errors++; $display("FAIL pass_done_cycle got %0d want 52", r_done_cyc);
    end
  endtask

  task automatic test_backpressure();
    arr_t d, e;
    for (int i = 0; i < 25; i++) d[i] = 8'($urandom);
    e = ref_model(1'b1, d);
    run_txn(1'b1, d, 40, 7, 3, 1'b0, 1'b0, -1);
    checks++;
    if (r_to || r_got.size() != 25) begin
      errors++; $display("FAIL bp_count got %0d want 25", r_got.size());
    end
    checks++;
    if (r_held.size() != 3) begin
      errors++; $display("FAIL bp_stall_len got %0d want 3", r_held.size());
    end
    foreach (r_held[k]) begin
      checks++;
      if (r_held[k] !== e[7]) begin
        errors++; $display("FAIL bp_hold[%0d] got %h want %h", k, r_held[k], e[7]);
      end
    end
    for (int i = 0; i < 25; i++) begin
      logic [7:0] g;
      g = (i < r_got.size()) ? r_got[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errors++; $display("FAIL bp_elem[%0d] got %h want %h", i, g, e[i]);
      end
    end
    checks++;
    if (r_lastcnt != 1 || r_lastpos != 24) begin
      errors++;
      $display("FAIL bp_last got cnt=%0d pos=%0d want cnt=1 pos=24",
               r_lastcnt, r_lastpos);
    end
  endtask

  task automatic test_back_to_back();
    arr_t d, e;
    bit op;
    op = 1'($urandom_range(1));
    for (int i = 0; i < 25; i++) d[i] = 8'($urandom);
    e = ref_model(op, d);
    run_txn(op, d, 20, -1, 0, 1'b1, 1'b0, -1);
    checks++;
    if (r_busy_cmd != 0) begin
      errors++; $display("FAIL b2b_cmd_ready_busy got %0d want 0", r_busy_cmd);
    end
    checks++;
    if (r_done_cmdrdy !== 1'b1) begin
      errors++; $display("FAIL b2b_done_cmd_ready got %b want 1", r_done_cmdrdy);
    end
    for (int i = 0; i < 25; i++) begin
      logic [7:0] g;
      g = (i < r_got.size()) ? r_got[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errors++; $display("FAIL b2b1_elem[%0d] got %h want %h", i, g, e[i]);
      end
    end
    for (int i = 0; i < 25; i++) d[i] = 8'($urandom);
    e = ref_model(1'b1, d);
    run_txn(1'b1, d, 0, -1, 0, 1'b0, 1'b0, -1);
    checks++;
    if (r_wait != 0) begin
      errors++; $display("FAIL b2b_accept_wait got %0d want 0", r_wait);
    end
    checks++;
    if (r_done_cyc != 52) begin
      errors++; $display("FAIL b2b_done_cycle got %0d want 52", r_done_cyc);
    end
    for (int i = 0; i < 25; i++) begin
      logic [7:0] g;
      g = (i < r_got.size()) ? r_got[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errors++; $display("FAIL b2b2_elem[%0d] got %h want %h", i, g, e[i]);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    arr_t d, e;
    int bad;
    for (int i = 0; i < 25; i++) d[i] = 8'($urandom);
    run_txn(1'b1, d, 0, -1, 0, 1'b0, 1'b0, 12);
    checks++;
    if (!r_aborted) begin
      errors++; $display("FAIL rmd_reached got 0 want 1");
    end
    checks++;
    if (r_ab_ov !== 1'b0 || r_ab_busy !== 1'b0) begin
      errors++;
      $display("FAIL rmd_abort got out_valid=%b busy=%b want 0 0",
               r_ab_ov, r_ab_busy);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy || bus.out_valid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rmd_quiet got %0d active cycles want 0", bad);
    end
    for (int i = 0; i < 25; i++) d[i] = 8'($urandom);
    e = ref_model(1'b1, d);
    run_txn(1'b1, d, 10, -1, 0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 25; i++) begin
      logic [7:0] g;
      g = (i < r_got.size()) ? r_got[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errors++; $display("FAIL rmd_elem[%0d] got %h want %h", i, g, e[i]);
      end
    end
  endtask

  task automatic test_spurious();
    arr_t d, e;
    int bad;
    bad = 0;
    repeat (5) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom);
      bus.out_ready = 1'b1;
      if (bus.in_ready || bus.busy || bus.out_valid) bad++;
      @(posedge clk); #1;
    end
    if (bus.in_ready || bus.busy || bus.out_valid) bad++;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL spur_idle got %0d bad cycles want 0", bad);
    end
    for (int i = 0; i < 25; i++) d[i] = 8'($urandom);
    e = ref_model(1'b0, d);
    run_txn(1'b0, d, 30, -1, 0, 1'b0, 1'b1, -1);
    checks++;
    if (r_spur_bad != 0) begin
      errors++; $display("FAIL spur_in_ready got %0d want 0", r_spur_bad);
    end
    checks++;
    if (r_to || r_got.size() != 25) begin
      errors++; $display("FAIL spur_count got %0d want 25", r_got.size());
    end
    for (int i = 0; i < 25; i++) begin
      logic [7:0] g;
      g = (i < r_got.size()) ? r_got[i] : 8'hxx;
      checks++;
      if (g !== e[i]) begin
        errors++; $display("FAIL spur_elem[%0d] got %h want %h", i, g, e[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transpose();
    test_pass();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
